// File: rtl/mux8_pkg.sv
// Shared constants, state encoding and helpers for the 8-way mux scheduler.
package mux8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  // Scheduler states. The encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_e;

  // Turn a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: returns the first set REQ bit searching upward
// from PTR and wrapping from 7 back to 0.
module rr_pick8
  import mux8_pkg::*;
(
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [SEL_W-1:0]   PTR,
  output logic               ANY,
  output logic [SEL_W-1:0]   IDX
);

  logic [SEL_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit to PTR wins last.
  always_comb begin
    ANY  = 1'b0;
    IDX  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = PTR + SEL_W'(i);
      if (REQ[cand]) begin
        ANY = 1'b1;
        IDX = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for the shared 8:1 mux: grants one requester for a
// fixed burst, then inserts one idle gap before re-arbitrating.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no grant; arbitrate every cycle
// XFER    | burst active; GNT/SEL/VALID driven, counter tracks beats
// GAP     | one dead cycle after a burst; SEL held, arbitration runs
module mux8_rr_sched
  import mux8_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic               VALID,
  output logic               LAST
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic               valid_q, valid_d;
  logic               last_q,  last_d;
  logic [SEL_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;

  rr_pick8 u_pick (
    .REQ (REQ),
    .PTR (ptr_q),
    .ANY (pick_any),
    .IDX (pick_idx)
  );

  // Next-state and next-output computation; SEL and PTR hold unless a new
  // grant is issued so the mux select never glitches during GAP/IDLE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_any) begin
          state_d = ST_XFER;
          gnt_d   = onehot8(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
          last_d  = (CNT_ONE == CNT_LAST);
          ptr_d   = pick_idx + SEL_W'(1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end

      ST_XFER: begin
        // Burst ends after the LAST beat, or early if the owner drops REQ.
        if (!REQ[sel_q] || (cnt_q == CNT_LAST)) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          last_d = ((cnt_q + CNT_ONE) == CNT_LAST);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = valid_q;
  assign LAST  = last_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: four instances with different burst lengths share
// clock, reset and REQ; a cycle-level reference model checks all of them
// every cycle, with directed table vectors and hand sequences on top.
module tb_mux8_rr_sched;

  localparam int NDUT = 4;

  function automatic int bl_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt_w   [NDUT];
  logic [2:0] sel_w   [NDUT];
  logic       valid_w [NDUT];
  logic       last_w  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mux8_rr_sched #(.BURST_LEN(bl_of(g))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .REQ   (req),
      .GNT   (gnt_w[g]),
      .SEL   (sel_w[g]),
      .VALID (valid_w[g]),
      .LAST  (last_w[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the mux, how many beats delivered, next priority.
  bit m_active [NDUT];
  int m_owner  [NDUT];
  int m_beats  [NDUT];
  int m_ptr    [NDUT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_active[k] = 1'b0;
      m_owner[k]  = 0;
      m_beats[k]  = 0;
      m_ptr[k]    = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r);
    int c;
    for (int k = 0; k < NDUT; k++) begin
      if (m_active[k]) begin
        if (r[m_owner[k]] == 1'b0 || m_beats[k] == bl_of(k)) m_active[k] = 1'b0;
        else m_beats[k] = m_beats[k] + 1;
      end else begin
        for (int off = 0; off < 8; off++) begin
          c = (m_ptr[k] + off) % 8;
          if (r[c] && !m_active[k]) begin
            m_active[k] = 1'b1;
            m_owner[k]  = c;
            m_beats[k]  = 1;
            m_ptr[k]    = (c + 1) % 8;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    logic       el;
    for (int k = 0; k < NDUT; k++) begin
      eg = m_active[k] ? (8'h01 << m_owner[k]) : 8'h00;
      el = m_active[k] && (m_beats[k] == bl_of(k));
      chk($sformatf("model dut%0d {gnt,sel,valid,last}", k),
          {19'd0, gnt_w[k], sel_w[k], valid_w[k], last_w[k]},
          {19'd0, eg, 3'(m_owner[k]), m_active[k], el});
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(req);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic chk_dut(input string name, input int k, input logic [7:0] g,
                         input logic [2:0] s, input logic v, input logic l);
    chk(name, {19'd0, gnt_w[k], sel_w[k], valid_w[k], last_w[k]}, {19'd0, g, s, v, l});
  endtask

  typedef struct {
    bit         do_reset;
    int         dut;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       last;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit rs, input int d, input logic [7:0] r, input logic [7:0] g,
                         input logic [2:0] s, input logic v, input logic l);
    vec_t t;
    t.do_reset = rs; t.dut = d; t.req = r; t.gnt = g; t.sel = s; t.valid = v; t.last = l;
    vecs.push_back(t);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Burst length 4, single requester 0.
    add_vec(1, 0, 8'h01, 8'h01, 3'd0, 1, 0);
    add_vec(0, 0, 8'h01, 8'h01, 3'd0, 1, 0);
    add_vec(0, 0, 8'h01, 8'h01, 3'd0, 1, 0);
    add_vec(0, 0, 8'h01, 8'h01, 3'd0, 1, 1);
    add_vec(0, 0, 8'h01, 8'h00, 3'd0, 0, 0);
    add_vec(0, 0, 8'h01, 8'h01, 3'd0, 1, 0);
    // Burst length 1, requesters 4 and 7 alternate.
    add_vec(1, 3, 8'h90, 8'h10, 3'd4, 1, 1);
    add_vec(0, 3, 8'h90, 8'h00, 3'd4, 0, 0);
    add_vec(0, 3, 8'h90, 8'h80, 3'd7, 1, 1);
    add_vec(0, 3, 8'h90, 8'h00, 3'd7, 0, 0);
    add_vec(0, 3, 8'h90, 8'h10, 3'd4, 1, 1);

    do_reset();
    chk_dut("reset dut0", 0, 8'h00, 3'd0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) do_reset();
      req = vecs[i].req;
      cycle();
      chk_dut($sformatf("vec%0d", i), vecs[i].dut, vecs[i].gnt, vecs[i].sel,
              vecs[i].valid, vecs[i].last);
    end

    // All requesting, burst length 2: select walks 0..7 then wraps to 0.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      cycle();
      chk_dut($sformatf("rr beat1 g%0d", g), 1, 8'h01 << (g % 8), 3'(g % 8), 1, 0);
      cycle();
      chk_dut($sformatf("rr beat2 g%0d", g), 1, 8'h01 << (g % 8), 3'(g % 8), 1, 1);
      cycle();
      chk_dut($sformatf("rr gap g%0d", g), 1, 8'h00, 3'(g % 8), 0, 0);
    end

    // Pointer wrap: after a grant to 5, REQ=21 goes to 0 first, then 5.
    do_reset();
    req = 8'h20;
    cycle();
    chk_dut("wrap grant5", 3, 8'h20, 3'd5, 1, 1);
    req = 8'h21;
    cycle();
    chk_dut("wrap gap", 3, 8'h00, 3'd5, 0, 0);
    cycle();
    chk_dut("wrap grant0", 3, 8'h01, 3'd0, 1, 1);
    cycle();
    cycle();
    chk_dut("wrap regrant5", 3, 8'h20, 3'd5, 1, 1);

    // Early abort of an 8-beat burst to requester 3 in its second beat.
    do_reset();
    req = 8'h08;
    cycle();
    chk_dut("abort beat1", 2, 8'h08, 3'd3, 1, 0);
    cycle();
    chk_dut("abort beat2", 2, 8'h08, 3'd3, 1, 0);
    req = 8'h40;
    cycle();
    chk_dut("abort gap", 2, 8'h00, 3'd3, 0, 0);
    cycle();
    chk_dut("abort next grant", 2, 8'h40, 3'd6, 1, 0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req = 8'hFF;
    cycle();
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++)
      chk_dut($sformatf("async rst dut%0d", k), k, 8'h00, 3'd0, 0, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    req = 8'hFF;
    cycle();
    chk_dut("post-rst grant0", 2, 8'h01, 3'd0, 1, 0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       req = 8'($urandom);
          1:       req = 8'h01 << $urandom_range(0, 7);
          default: req = req ^ (8'h01 << $urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares the 8:1 single-bit mux between eight requesters. It drives the mux select lines and a one-hot grant vector, holding each grant for a fixed-length burst. It then inserts one idle gap cycle before re-arbitrating. It sits directly in front of the `mux8x1` instance: `SEL[0]`/`SEL[1]`/`SEL[2]` connect to `S0`/`S1`/`S2`, and requester *i* drives data input *Ii*.

## Interface
Parameters:
- `BURST_LEN`, default 8: cycles per grant. Legal range 1..255.
- `CNT_W`, default `$clog2(BURST_LEN+1)`: burst counter width. Derived; do not override.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `REQ`, input, 8: request per requester. Level-sensitive; held high while the requester has data.
- `GNT`, output, 8: one-hot grant. All zero when no grant is active. Registered.
- `SEL`, output, 3: mux select, equal to the index of the granted requester. Registered.
- `VALID`, output, 1: the mux output carries granted data this cycle. Registered.
- `LAST`, output, 1: final cycle of the current burst. Registered.

## Operation
- States: IDLE, XFER, GAP.
- Reset values: state=IDLE, `GNT`=0, `SEL`=0, `VALID`=0, `LAST`=0, priority pointer `PTR`=0, counter=0.
- Arbitration happens in IDLE and in GAP.
  - The winner is the first asserted `REQ` bit searching upward from `PTR`, wrapping from 7 to 0.
  - If any `REQ` bit is set, the next state is XFER. On that edge, `GNT` = one-hot(winner), `SEL` = winner, `VALID` = 1, counter = 1, and `PTR` = (winner+1) mod 8.
  - If no `REQ` bit is set, the next state is IDLE, with `GNT`=0 and `VALID`=0.
- XFER:
  - The counter increments each cycle.
  - `LAST` = 1 in the cycle where counter == `BURST_LEN`.
  - After the `LAST` cycle, the next state is GAP, with `GNT`=0, `VALID`=0, `LAST`=0.
  - Early abort: if `REQ[SEL]` is 0 in any XFER cycle, the next state is GAP. `LAST` is not asserted for an aborted burst.
- GAP: exactly one cycle with `VALID`=0 and `GNT`=0. `SEL` holds its last value so the mux output does not glitch. Arbitration for the next grant runs in this cycle.
- Requests from non-granted requesters never preempt an active burst.
- With `BURST_LEN`=1, the first XFER cycle has `LAST`=1.

## Timing
- Request-to-grant latency: `REQ` seen at edge *t* in IDLE or GAP gives `GNT`/`VALID` high from *t*+1.
- A full burst has `VALID` high for exactly `BURST_LEN` consecutive cycles.
- `LAST` rises coincident with the final `VALID` cycle.
- The grant-to-grant period under continuous requests is `BURST_LEN`+1 cycles (burst plus gap).
- Abort: `REQ[SEL]` low at edge *t* gives `VALID` low from *t*+1.
- Asynchronous reset mid-burst:
  - All outputs go to their reset values immediately.
  - `PTR` returns to 0.
  - After `rst_n` rises, the first arbitration is on the first clock edge.
- All outputs are registered. There is no combinational path from `REQ` to any output.

## Structure
- Shared package `mux8_pkg` holds:
  - `NUM_REQ`=8 and `SEL_W`=3.
  - The state encoding: IDLE=2'd0, XFER=2'd1, GAP=2'd2. Value 3 is illegal and must recover to IDLE.
- Sub-module `rr_pick8`: combinational rotate-priority picker.
  - Inputs: `REQ[7:0]` and `PTR[2:0]`.
  - Outputs: `ANY` and `IDX[2:0]`.
  - The same module is reused for other 8-way sharing.
- The top module contains the FSM, the counter, `PTR`, and the output registers.

## Test plan
- Reset, then `REQ`=8'h01 held, `BURST_LEN`=4 → from the edge after reset release: `GNT`=01, `SEL`=0, `VALID` high for 4 cycles with `LAST` on the 4th, one gap cycle, then re-grant to 0.
- `REQ`=8'hFF held, `BURST_LEN`=2 → `SEL` sequence 0,1,2,…,7,0, each grant lasting 2 `VALID` cycles plus 1 gap cycle; `GNT` always one-hot or zero.
- `PTR`=6 after a grant to 5, then `REQ`=8'h21 → winner is 0 (wrap), not 5. Next grant with the same `REQ` goes to 5.
- During a grant to 3, drop `REQ[3]` in the 2nd cycle of an 8-cycle burst → `VALID` low in the next cycle, `LAST` never asserted, GAP follows, then the next requester is granted.
- `BURST_LEN`=1 with `REQ`=8'h90 → alternating grants to 4 and 7. Each grant is a single `VALID` cycle with `LAST`=1, separated by one gap.
- Assert `rst_n` low mid-burst → `GNT`, `SEL`, `VALID`, `LAST` go to 0 without waiting for a clock edge. After release with `REQ`=8'hFF, the first grant goes to 0.
